// File: rtl/spw_fifo_pkg.sv
// Shared constants, N-Char layout and depth helper for the SpaceWire character FIFO.
package spw_fifo_pkg;

  localparam int unsigned FIFO_DWIDTH    = 9;
  localparam int unsigned FIFO_AWIDTH    = 6;
  localparam int unsigned NCHAR_CTRL_BIT = 8;
  localparam int unsigned NCHAR_DATA_MSB = 7;

  // N-Char as carried through the FIFO: control flag above 8 data bits.
  typedef struct packed {
    logic       ctrl;
    logic [7:0] data;
  } nchar_t;

  // Number of storage entries for a given address width.
  function automatic int unsigned fifo_depth(input int unsigned awidth);
    return 32'(1) << awidth;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy, threshold and error-flag management for fifo_mem_ctrl.
// Pointers carry one extra wrap bit above the memory address.
module fifo_ptr_ctrl
  import spw_fifo_pkg::*;
#(
  parameter int unsigned AWIDTH   = FIFO_AWIDTH,
  parameter int unsigned AF_LEVEL = 56,
  parameter int unsigned AE_LEVEL = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              wr_en_i,
  input  logic              rd_en_i,
  output logic              wr_accept_c_o,
  output logic              rd_accept_c_o,
  output logic [AWIDTH-1:0] wr_addr_o,
  output logic [AWIDTH-1:0] rd_addr_o,
  output logic [AWIDTH:0]   count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int unsigned PW = AWIDTH + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          af_q, af_d, ae_q, ae_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;

  // Accept logic, next pointers/count and flags computed from the next state.
  always_comb begin
    rd_accept_c_o = rd_en_i & ~empty_q & ~flush_i;
    wr_accept_c_o = wr_en_i & ~flush_i & (~full_q | rd_accept_c_o);
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    ovf_d         = ovf_q;
    unf_d         = unf_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_accept_c_o) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_accept_c_o) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_accept_c_o, rd_accept_c_o})
        2'b10:   count_d = count_q + PW'(1);
        2'b01:   count_d = count_q - PW'(1);
        default: count_d = count_q;
      endcase
      if (wr_en_i & ~wr_accept_c_o) ovf_d = 1'b1;
      if (rd_en_i & empty_q)        unf_d = 1'b1;
    end
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[AWIDTH-1:0] == rd_ptr_d[AWIDTH-1:0]) &&
              (wr_ptr_d[AWIDTH] != rd_ptr_d[AWIDTH]);
    af_d    = (count_d >= PW'(AF_LEVEL));
    ae_d    = (count_d <= PW'(AE_LEVEL));
  end

  // State registers; flags are registered alongside count so they move together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign wr_addr_o      = wr_ptr_q[AWIDTH-1:0];
  assign rd_addr_o      = rd_ptr_q[AWIDTH-1:0];
  assign count_o        = count_q;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = af_q;
  assign almost_empty_o = ae_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

endmodule

// File: rtl/fifo_mem_ctrl.sv
// Synchronous character FIFO between the SpaceWire link FSM and the host side.
// Option: define FIFO_REG_OUT_EN for a registered read port (1-cycle latency);
// otherwise the FIFO is show-ahead and data_out presents the head word.
module fifo_mem_ctrl
  import spw_fifo_pkg::*;
#(
  parameter int unsigned DWIDTH   = FIFO_DWIDTH,
  parameter int unsigned AWIDTH   = FIFO_AWIDTH,
  parameter int unsigned AF_LEVEL = 56,
  parameter int unsigned AE_LEVEL = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              rd_en,
  output logic [DWIDTH-1:0] data_out,
  output logic              data_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AWIDTH:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned DEPTH = fifo_depth(AWIDTH);

  // Threshold configuration sanity checks.
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af_level
    $error("fifo_mem_ctrl: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL > DEPTH - 1) begin : g_bad_ae_level
    $error("fifo_mem_ctrl: AE_LEVEL out of range 0..DEPTH-1");
  end

  logic              wr_accept_c, rd_accept_c;
  logic [AWIDTH-1:0] wr_addr, rd_addr;
  logic [DWIDTH-1:0] mem_q [DEPTH];

  fifo_ptr_ctrl #(
    .AWIDTH  (AWIDTH),
    .AF_LEVEL(AF_LEVEL),
    .AE_LEVEL(AE_LEVEL)
  ) u_ptr_ctrl (
    .clock         (clock),
    .reset         (reset),
    .flush_i       (flush),
    .wr_en_i       (wr_en),
    .rd_en_i       (rd_en),
    .wr_accept_c_o (wr_accept_c),
    .rd_accept_c_o (rd_accept_c),
    .wr_addr_o     (wr_addr),
    .rd_addr_o     (rd_addr),
    .count_o       (count),
    .full_o        (full),
    .empty_o       (empty),
    .almost_full_o (almost_full),
    .almost_empty_o(almost_empty),
    .overflow_o    (overflow),
    .underflow_o   (underflow)
  );

  // Storage array: cleared only by reset, written on accepted writes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_accept_c) begin
      mem_q[wr_addr] <= data_in;
    end
  end

`ifdef FIFO_REG_OUT_EN
  logic [DWIDTH-1:0] data_out_q;
  logic              data_valid_q;

  // Registered read port: head word captured on an accepted read, valid for one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else if (flush) begin
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= rd_accept_c;
      if (rd_accept_c) data_out_q <= mem_q[rd_addr];
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
`else
  // Show-ahead read port: head word visible whenever the FIFO holds data.
  assign data_out   = empty ? '0 : mem_q[rd_addr];
  assign data_valid = ~empty;
`endif

endmodule
